// File: rtl/alu_defs_pkg.sv
// Opcode, branch-compare and FSM-state encodings shared by the execute unit
// and the ALU control decoder.
package alu_defs_pkg;

  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_MUL  = 4'b0011;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
  localparam logic [3:0] ALU_OP_NOR  = 4'b1100;
  localparam logic [3:0] ALU_OP_NAND = 4'b1101;

  localparam logic [2:0] ALU_EX_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_EX_OP_SGT  = 3'b001;
  localparam logic [2:0] ALU_EX_OP_SGE  = 3'b011;
  localparam logic [2:0] ALU_EX_OP_SNE  = 3'b100;
  localparam logic [2:0] ALU_EX_OP_SEQ  = 3'b110;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_MUL_ENC  = 1'b1;

  typedef enum logic {
    ST_IDLE = ST_IDLE_ENC,
    ST_MUL  = ST_MUL_ENC
  } state_e;

endpackage

// File: rtl/alu_exec_unit_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per clock.
// done_o/prod_o are valid combinationally during the final step so the
// caller can register the product on the same edge that retires it.
module iter_mul #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] prod_o
);

  localparam int N     = DATA_W / MUL_BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] w_part;
  logic              w_last;

  // Partial product of this step: multiplicand times the low MUL_BPC multiplier bits.
  always_comb begin
    w_part = {DATA_W{1'b0}};
    for (int k = 0; k < MUL_BPC; k++) begin
      w_part = w_part + (r_mplier[k] ? (r_mcand << k) : {DATA_W{1'b0}});
    end
  end

  assign w_last = r_busy && (r_cnt == LAST_STEP);
  assign done_o = w_last && !flush_i;
  assign busy_o = r_busy;
  assign prod_o = r_acc + w_part;

  // Operand capture, one shift-add step per clock, flush abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mcand  <= {DATA_W{1'b0}};
      r_mplier <= {DATA_W{1'b0}};
      r_acc    <= {DATA_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
    end else if (flush_i) begin
      r_busy <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (r_busy) begin
      r_acc    <= r_acc + w_part;
      r_mcand  <= r_mcand << MUL_BPC;
      r_mplier <= r_mplier >> MUL_BPC;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= 1'b1;
      end
    end else if (start_i) begin
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_acc    <= {DATA_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b1;
    end else begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle ALU ops, iterative MUL with busy stall,
// and the branch-condition flag, all presented through registered outputs.
module alu_exec_unit
  import alu_defs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [3:0]        ALU_ctrl_i,
  input  logic [2:0]        ALU_ex_ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              branch_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int SH_W = $clog2(DATA_W);

  state_e            r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_branch;
  logic              r_valid;
  logic              r_busy;
  logic              r_mul_branch;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_cmp;
  logic [SH_W-1:0]   w_sh;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_prod;

  assign w_sh = src1_i[SH_W-1:0];

  // Single-cycle datapath; unknown codes (including MUL here) yield zero.
  always_comb begin
    w_alu_res = {DATA_W{1'b0}};
    case (ALU_ctrl_i)
      ALU_OP_AND:  w_alu_res = src1_i & src2_i;
      ALU_OP_OR:   w_alu_res = src1_i | src2_i;
      ALU_OP_ADD:  w_alu_res = src1_i + src2_i;
      ALU_OP_SUB:  w_alu_res = src1_i - src2_i;
      ALU_OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_OP_SLL:  w_alu_res = src2_i << w_sh;
      ALU_OP_SRL:  w_alu_res = src2_i >> w_sh;
      ALU_OP_NOR:  w_alu_res = ~(src1_i | src2_i);
      ALU_OP_NAND: w_alu_res = ~(src1_i & src2_i);
      default:     w_alu_res = {DATA_W{1'b0}};
    endcase
  end

  // Branch compare straight off the operands, independent of the ALU opcode.
  always_comb begin
    w_cmp = 1'b0;
    case (ALU_ex_ctrl_i)
      ALU_EX_OP_SGT: w_cmp = $signed(src1_i) >  $signed(src2_i);
      ALU_EX_OP_SGE: w_cmp = $signed(src1_i) >= $signed(src2_i);
      ALU_EX_OP_SNE: w_cmp = src1_i != src2_i;
      ALU_EX_OP_SEQ: w_cmp = src1_i == src2_i;
      default:       w_cmp = 1'b0;
    endcase
  end

  assign w_mul_start = start_i && !flush_i && (r_state == ST_IDLE) &&
                       (ALU_ctrl_i == ALU_OP_MUL);

  iter_mul #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_iter_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_mul_start),
    .flush_i (flush_i),
    .a_i     (src1_i),
    .b_i     (src2_i),
    .busy_o  (w_mul_busy),
    .done_o  (w_mul_done),
    .prod_o  (w_mul_prod)
  );

  // Control FSM and output registers; a multiplier that goes idle without done is treated as aborted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_result     <= {DATA_W{1'b0}};
      r_zero       <= 1'b1;
      r_branch     <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_mul_branch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_i) begin
            r_valid <= 1'b0;
          end else if (start_i && (ALU_ctrl_i == ALU_OP_MUL)) begin
            r_state      <= ST_MUL;
            r_busy       <= 1'b1;
            r_valid      <= 1'b0;
            r_mul_branch <= w_cmp;
          end else if (start_i) begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == {DATA_W{1'b0}});
            r_branch <= w_cmp;
            r_valid  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (flush_i || !w_mul_busy) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end else if (w_mul_done) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_result <= w_mul_prod;
            r_zero   <= (w_mul_prod == {DATA_W{1'b0}});
            r_branch <= r_mul_branch;
            r_valid  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign branch_o = r_branch;
  assign valid_o  = r_valid;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: randomized issue against a
// behavioural arithmetic model, plus the directed MUL/flush/reset scenarios.
module tb_alu_exec_unit;

  localparam int N = 32;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_MUL = 4'b0011, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                         OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_NOR = 4'b1100,
                         OP_NAND = 4'b1101;
  localparam logic [2:0] EX_NONE = 3'b000, EX_SGT = 3'b001, EX_SGE = 3'b011,
                         EX_SNE = 3'b100, EX_SEQ = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic [3:0]  op = 4'd0;
  logic [2:0]  ex = 3'd0;
  logic [31:0] result;
  logic        zero, branch, valid, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_result = 32'd0;
  logic        m_branch = 1'b0;

  alu_exec_unit #(.DATA_W(32), .MUL_BPC(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .src1_i(src1), .src2_i(src2), .ALU_ctrl_i(op), .ALU_ex_ctrl_i(ex),
    .result_o(result), .zero_o(zero), .branch_o(branch),
    .valid_o(valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_MUL:  return a * b;
      OP_SUB:  return a - b;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (c)
      EX_SGT:  return sa > sb;
      EX_SGE:  return sa >= sb;
      EX_SNE:  return a != b;
      EX_SEQ:  return a == b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] pick_op(input int idx);
    case (idx)
      0: return OP_AND;   1: return OP_OR;    2: return OP_ADD;
      3: return OP_SUB;   4: return OP_SLT;   5: return OP_SLL;
      6: return OP_SRL;   7: return OP_NOR;   8: return OP_NAND;
      9: return 4'b0100;  10: return 4'b1010; default: return 4'b1111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got=%b exp=1", zero); end
    vectors++; if ({branch, valid, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {branch, valid, busy}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    op = OP_ADD; ex = EX_NONE; src1 = 32'd5; src2 = 32'd7; start = 1'b1;
    m_result = ref_alu(op, src1, src2);
    step();
    start = 1'b0;
    vectors++; if (result !== m_result) begin miscompares++; $display("FAIL add_result got=%h exp=%h", result, m_result); end
    vectors++; if ({valid, zero, busy} !== 3'b100) begin miscompares++; $display("FAIL add_flags got=%b exp=100", {valid, zero, busy}); end
    step();
    vectors++; if (valid !== 1'b0 || result !== m_result) begin miscompares++; $display("FAIL add_hold valid=%b result=%h exp valid=0 result=%h", valid, result, m_result); end
  endtask

  task automatic test_back_to_back();
    op = OP_SUB; ex = EX_NONE; src1 = 32'd3; src2 = 32'd5; start = 1'b1;
    m_result = ref_alu(op, src1, src2);
    step();
    vectors++; if (result !== m_result || valid !== 1'b1) begin miscompares++; $display("FAIL b2b_sub result=%h valid=%b exp=%h/1", result, valid, m_result); end
    op = OP_SLT; src1 = 32'hFFFF_FFFF; src2 = 32'd0;
    m_result = ref_alu(op, src1, src2);
    step();
    start = 1'b0;
    vectors++; if (result !== m_result || valid !== 1'b1) begin miscompares++; $display("FAIL b2b_slt result=%h valid=%b exp=%h/1", result, valid, m_result); end
    step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle valid got=%b exp=0", valid); end
  endtask

  task automatic test_random_single();
    logic exp_v;
    for (int i = 0; i < 80; i++) begin
      start = ($urandom_range(0, 3) != 0);
      op    = pick_op($urandom_range(0, 11));
      ex    = 3'($urandom_range(0, 7));
      src1  = $urandom();
      src2  = ($urandom_range(0, 3) == 0) ? src1 : $urandom();
      if ($urandom_range(0, 3) == 0) src1 = {27'd0, src1[4:0]};
      exp_v = start;
      if (start) begin
        m_result = ref_alu(op, src1, src2);
        m_branch = ref_br(ex, src1, src2);
      end
      step();
      vectors++; if (valid !== exp_v) begin miscompares++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, valid, exp_v); end
      vectors++; if (result !== m_result) begin miscompares++; $display("FAIL rnd_result i=%0d op=%b got=%h exp=%h", i, op, result, m_result); end
      vectors++; if (branch !== m_branch) begin miscompares++; $display("FAIL rnd_branch i=%0d ex=%b got=%b exp=%b", i, ex, branch, m_branch); end
      vectors++; if (zero !== (m_result == 32'd0) || busy !== 1'b0) begin miscompares++; $display("FAIL rnd_zero_busy i=%0d got=%b%b exp=%b0", i, zero, busy, (m_result == 32'd0)); end
    end
    start = 1'b0;
  endtask

  // Runs one multiply issued now; optional ignored ADD start at edge add_at.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input int add_at, input string tag);
    logic seen = 1'b0;
    op = OP_MUL; ex = c; src1 = a; src2 = b; start = 1'b1;
    m_result = ref_alu(OP_MUL, a, b);
    m_branch = ref_br(c, a, b);
    step();
    start = 1'b0; src1 = $urandom(); src2 = $urandom();
    vectors++; if (busy !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL %s_issue busy=%b valid=%b exp=1/0", tag, busy, valid); end
    for (int k = 1; k <= N + 4; k++) begin
      if (k == add_at) begin
        op = OP_ADD; src1 = 32'd1; src2 = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      vectors++; if (valid !== (k == N)) begin miscompares++; $display("FAIL %s_valid edge=%0d got=%b exp=%b", tag, k, valid, (k == N)); end
      vectors++; if (busy !== (k < N)) begin miscompares++; $display("FAIL %s_busy edge=%0d got=%b exp=%b", tag, k, busy, (k < N)); end
      if (valid === 1'b1) seen = 1'b1;
      if (k == N) begin
        vectors++; if (result !== m_result || branch !== m_branch) begin miscompares++; $display("FAIL %s_product got=%h/%b exp=%h/%b", tag, result, branch, m_result, m_branch); end
      end
    end
    start = 1'b0;
    vectors++; if (!seen) begin miscompares++; $display("FAIL %s_timeout no valid within %0d cycles", tag, N + 4); end
    vectors++; if (result !== m_result) begin miscompares++; $display("FAIL %s_hold got=%h exp=%h", tag, result, m_result); end
  endtask

  task automatic test_mul();
    run_mul(32'd7, 32'hFFFF_FFFD, EX_NONE, 5, "mul7x-3");
    for (int i = 0; i < 3; i++) run_mul($urandom(), $urandom(), 3'($urandom_range(0, 7)), 0, "mulrnd");
  endtask

  task automatic test_flush();
    logic [31:0] prev = m_result;
    op = OP_MUL; ex = EX_NONE; src1 = 32'h0001_0000; src2 = 32'h0001_0000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      step();
      vectors++; if (busy !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL flush_pre edge=%0d busy=%b valid=%b exp=1/0", k, busy, valid); end
    end
    flush = 1'b1; op = OP_ADD; src1 = 32'd4; src2 = 32'd4; start = 1'b1;
    step();
    flush = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0 || valid !== 1'b0 || result !== prev) begin miscompares++; $display("FAIL flush_mul busy=%b valid=%b result=%h exp=0/0/%h", busy, valid, result, prev); end
    for (int k = 0; k < N + 4; k++) begin
      step();
      vectors++; if (valid !== 1'b0 || busy !== 1'b0 || result !== prev) begin miscompares++; $display("FAIL flush_after cyc=%0d valid=%b busy=%b result=%h exp=0/0/%h", k, valid, busy, result, prev); end
    end
    flush = 1'b1; start = 1'b1; op = OP_ADD; src1 = 32'd5; src2 = 32'd7;
    step();
    flush = 1'b0; start = 1'b0;
    vectors++; if (valid !== 1'b0 || result !== prev) begin miscompares++; $display("FAIL flush_prio valid=%b result=%h exp=0/%h", valid, result, prev); end
    src1 = 32'd2; src2 = 32'd3; start = 1'b1;
    m_result = ref_alu(OP_ADD, src1, src2);
    step();
    start = 1'b0;
    vectors++; if (valid !== 1'b1 || result !== m_result) begin miscompares++; $display("FAIL flush_recover valid=%b result=%h exp=1/%h", valid, result, m_result); end
  endtask

  task automatic test_branches();
    logic [2:0]  cs [4] = '{EX_SGT, EX_SGE, EX_SNE, EX_SEQ};
    logic [31:0] as [4] = '{32'hFFFF_FFFF, 32'd0, 32'd4, 32'd9};
    logic [31:0] bs [4] = '{32'd0, 32'd0, 32'd0, 32'd9};
    for (int i = 0; i < 4; i++) begin
      ex = cs[i]; src1 = as[i]; src2 = bs[i]; op = pick_op($urandom_range(0, 11)); start = 1'b1;
      m_branch = ref_br(ex, src1, src2);
      m_result = ref_alu(op, src1, src2);
      step();
      vectors++; if (branch !== m_branch || valid !== 1'b1) begin miscompares++; $display("FAIL branch_%0d got=%b valid=%b exp=%b/1", i, branch, valid, m_branch); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_mul();
    op = OP_MUL; ex = EX_SEQ; src1 = $urandom(); src2 = $urandom(); start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #2 rst = 1'b1;
    #1;
    vectors++; if (result !== 32'd0 || {branch, valid, busy} !== 3'b000 || zero !== 1'b1) begin miscompares++; $display("FAIL rst_mid result=%h bvb=%b zero=%b exp=0/000/1", result, {branch, valid, busy}, zero); end
    step();
    #2 rst = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      step();
      vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_discard cyc=%0d valid=%b busy=%b exp=0/0", k, valid, busy); end
    end
    op = OP_ADD; ex = EX_NONE; src1 = 32'd1; src2 = 32'd1; start = 1'b1;
    m_result = ref_alu(op, src1, src2);
    step();
    start = 1'b0;
    vectors++; if (result !== m_result || valid !== 1'b1) begin miscompares++; $display("FAIL rst_add result=%h valid=%b exp=%h/1", result, valid, m_result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_random_single();
    test_mul();
    test_flush();
    test_branches();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
